// File: rtl/major_state_seq.sv
// ---------------------------------------------------------------------------
// MajorStateSeq -- major-state sequencer for a PDP-8 style processor.
//
// Walks each instruction through fetch, decode, optional deferred (indirect)
// read, optional autoindex write-back, and the execute cycles. It drives
// the memory handshake and issues single-cycle datapath strobes.
//
// Ports
//   clk        rising-edge system clock
//   reset      asynchronous, active-high; forces HALTED and clears the stop latch
//   RUN        start pulse (honoured only while HALTED)
//   STOP       request to halt at the end of the current instruction
//   MEMACK     memory cycle complete (ignored outside memory states)
//   ISZZERO    incremented ISZ operand is zero
//   AAND..OPR  one-hot decoded opcode, valid from DECODE onward
//   IND/PPIND/DIR  addressing mode: indirect, autoindex indirect, direct
//   MEMRD/MEMWR  memory read/write request, held until MEMACK
//   MASRC      address source: 0=PC, 1=IR page/offset, 2=MA register
//   LDIR, PCINC, LDMA, MDINC, ALUGO, CLRAC, LDPC, EXOP  one-cycle strobes
//   RUNNING    high in every state except HALTED
//   STATE      current major-state encoding for panel and debug
// ---------------------------------------------------------------------------
module major_state_seq (
   input  logic       clk,
   input  logic       reset,
   input  logic       RUN,
   input  logic       STOP,
   input  logic       MEMACK,
   input  logic       ISZZERO,
   input  logic       AAND,
   input  logic       TAD,
   input  logic       ISZ,
   input  logic       DCA,
   input  logic       JMS,
   input  logic       JMP,
   input  logic       IOT,
   input  logic       OPR,
   input  logic       IND,
   input  logic       PPIND,
   input  logic       DIR,
   output logic       MEMRD,
   output logic       MEMWR,
   output logic [1:0] MASRC,
   output logic       LDIR,
   output logic       PCINC,
   output logic       LDMA,
   output logic       MDINC,
   output logic       ALUGO,
   output logic       CLRAC,
   output logic       LDPC,
   output logic       EXOP,
   output logic       RUNNING,
   output logic [3:0] STATE
);

   typedef enum logic [3:0] {
      S_HALTED = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_DEFRD  = 4'd3,
      S_AUTOWR = 4'd4,
      S_EXRD   = 4'd5,
      S_EXWR   = 4'd6,
      S_EXJMP  = 4'd7,
      S_EXOPR  = 4'd8
   } state_t;

   state_t state_q, state_d;
   state_t execTarget;
   state_t decodeTarget;
   state_t routedState;
   logic   stopLatch_q, stopLatch_d;
   logic   stopEff;
   logic   decodeDirLoad;

   // Execute-phase routing of a memory-reference opcode once its effective
   // address is known. Anything unrecognised just goes back to fetch.
   always_comb begin
      execTarget = S_FETCH;
      if (JMP) begin
         execTarget = S_EXJMP;
      end else if (DCA || JMS) begin
         execTarget = S_EXWR;
      end else if (AAND || TAD || ISZ) begin
         execTarget = S_EXRD;
      end
   end

   // Routing out of DECODE. Operate/IOT never touch memory; indirect forms
   // take the deferred read first; direct forms go straight to execute and
   // load MA from the IR page/offset on the way.
   always_comb begin
      decodeTarget  = S_FETCH;
      decodeDirLoad = 1'b0;
      if (OPR || IOT) begin
         decodeTarget = S_EXOPR;
      end else if (IND || PPIND) begin
         decodeTarget = S_DEFRD;
      end else if (DIR) begin
         decodeTarget  = execTarget;
         decodeDirLoad = (execTarget != S_FETCH);
      end
   end

   // Next-state logic. A stop request is remembered until the machine would
   // next enter FETCH; at that point it lands in HALTED instead and the
   // latch is consumed. A STOP arriving in that very cycle counts too, which
   // is also what keeps RUN+STOP together from leaving HALTED.
   always_comb begin
      stopEff     = stopLatch_q | STOP;
      routedState = state_q;
      case (state_q)
         S_HALTED: if (RUN)    routedState = S_FETCH;
         S_FETCH:  if (MEMACK) routedState = S_DECODE;
         S_DECODE:             routedState = decodeTarget;
         S_DEFRD:  if (MEMACK) routedState = PPIND ? S_AUTOWR : execTarget;
         S_AUTOWR: if (MEMACK) routedState = execTarget;
         S_EXRD: begin
            if (MEMACK) begin
               if (AAND || TAD) begin
                  routedState = S_FETCH;
               end else if (ISZ) begin
                  routedState = S_EXWR;
               end else begin
                  routedState = S_FETCH;
               end
            end
         end
         S_EXWR:   if (MEMACK) routedState = S_FETCH;
         S_EXJMP:              routedState = S_FETCH;
         S_EXOPR:              routedState = S_FETCH;
         default:              routedState = S_HALTED;
      endcase

      state_d     = routedState;
      stopLatch_d = stopEff;
      if ((routedState == S_FETCH) && (state_q != S_FETCH) && stopEff) begin
         state_d     = S_HALTED;
         stopLatch_d = 1'b0;
      end
   end

   // State and stop-latch registers; reset lands in HALTED immediately so
   // every state-decoded output drops in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_HALTED;
         stopLatch_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         stopLatch_q <= stopLatch_d;
      end
   end

   // Output decode. Memory requests and MASRC depend only on state so they
   // stay stable while waiting for MEMACK; ack-qualified strobes fire
   // combinationally in the acking cycle.
   always_comb begin
      MEMRD   = 1'b0;
      MEMWR   = 1'b0;
      MASRC   = 2'd0;
      LDIR    = 1'b0;
      PCINC   = 1'b0;
      LDMA    = 1'b0;
      MDINC   = 1'b0;
      ALUGO   = 1'b0;
      CLRAC   = 1'b0;
      LDPC    = 1'b0;
      EXOP    = 1'b0;
      case (state_q)
         S_FETCH: begin
            MEMRD = 1'b1;
            MASRC = 2'd0;
            LDIR  = MEMACK;
            PCINC = MEMACK;
         end
         S_DECODE: begin
            MASRC = 2'd1;
            LDMA  = decodeDirLoad;
         end
         S_DEFRD: begin
            MEMRD = 1'b1;
            MASRC = 2'd1;
            MDINC = MEMACK & PPIND;
            LDMA  = MEMACK & ~PPIND;
         end
         S_AUTOWR: begin
            MEMWR = 1'b1;
            MASRC = 2'd1;
            LDMA  = MEMACK;
         end
         S_EXRD: begin
            MEMRD = 1'b1;
            MASRC = 2'd2;
            ALUGO = MEMACK & (AAND | TAD);
            MDINC = MEMACK & ISZ & ~(AAND | TAD);
         end
         S_EXWR: begin
            MEMWR = 1'b1;
            MASRC = 2'd2;
            CLRAC = MEMACK & DCA;
            LDPC  = MEMACK & JMS;
            PCINC = MEMACK & ISZ & ISZZERO;
         end
         S_EXJMP: LDPC = 1'b1;
         S_EXOPR: EXOP = 1'b1;
         default: ;
      endcase
   end

   assign RUNNING = (state_q != S_HALTED);
   assign STATE   = state_q;

endmodule
